axi_raddr_gen: RTL
==================

Name: axi_raddr_gen

Overview:
Parametrised AXI read-address generator for the DMA read path. It accepts one transfer command (start address, beat count), splits it into INCR bursts limited by MAX_BURST and the 4 KB boundary, and issues them on the AR channel. It tracks outstanding bursts via the R channel's last beat and signals completion. Compared with the current fixed-width generator, it computes 4 KB splitting automatically (no exceed-4K flag), supports AXI4 lengths up to 256, and adds an outstanding-burst limit.

Parameters:
ADDR_W, 32, address width
DATA_BYTES, 4, data bus width in bytes; power of 2, from 1 to 128
MAX_BURST, 16, maximum beats per burst; from 1 to 2^LEN_W and ≤256
LEN_W, 8, arlen width (4 gives AXI3)
CNT_W, 14, width of the command beat count
MAX_OUTST, 4, maximum number of issued bursts not yet completed by rlast; at least 1

Ports:
aclk  in  1  clock
areset  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_saddr  in  ADDR_W  start byte address
cmd_beats  in  CNT_W  total data beats
araddr  out  ADDR_W  AXI read address
arlen  out  LEN_W  beats-1
arsize  out  3  log2(DATA_BYTES), constant
arburst  out  2  2'b01 (INCR), constant
arvalid  out  1  AXI address valid
arready  in  1  AXI address ready
rlast_hs  in  1  pulse on rvalid&rready&rlast
busy  out  1  high from command acceptance until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async): state IDLE; arvalid=0, araddr=0, arlen=0, busy=0, done=0, outstanding=0, cmd_ready=1.
- States: IDLE, CALC, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On handshake, latch addr = cmd_saddr with the low log2(DATA_BYTES) bits forced to 0; latch rem = cmd_beats; set busy=1.
  - If cmd_beats==0, go to DRAIN.
  - Otherwise go to CALC.
- CALC (one cycle):
  - b4k = (4096 - addr[11:0]) / DATA_BYTES.
  - blen = min(rem, MAX_BURST, b4k).
  - Register araddr=addr and arlen=blen-1.
  - If outstanding < MAX_OUTST, go to ISSUE with arvalid=1; otherwise stay in CALC.
- ISSUE: arvalid stays high; araddr and arlen are held stable until arready=1.
  - On handshake: arvalid=0; addr += blen*DATA_BYTES; rem -= blen; outstanding++.
  - If the new rem==0, go to DRAIN; otherwise go to CALC.
- Latency:
  - arvalid is first high in the 2nd cycle after the command handshake edge.
  - After each AR handshake there is one CALC bubble cycle before the next arvalid.
- Outstanding counter:
  - +1 on AR handshake, −1 on rlast_hs; unchanged if both occur in the same cycle.
  - rlast_hs when the counter is 0 is ignored; the counter saturates at 0.
- DRAIN: when outstanding==0, pulse done=1 for one cycle, set busy=0, return to IDLE. cmd_ready rises the cycle after done.
- No burst crosses a 4 KB boundary. An address exactly on the boundary gives b4k=4096/DATA_BYTES.
- cmd_saddr and cmd_beats are sampled only at the handshake; later changes are ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- Reset mid-operation: all state is abandoned immediately and arvalid drops asynchronously. The R-channel owner must also be reset.

Test Plan:
1. DATA_BYTES=4, MAX_BURST=16; saddr=0x0, beats=50, arready=1, one rlast_hs per burst -> AR sequence (0x000, len15), (0x040, len15), (0x080, len15), (0x0C0, len1); one bubble cycle between bursts; done pulses once after the 4th rlast_hs.
2. saddr=0xFF5 (aligned to 0xFF4), beats=50 -> (0xFF4, len2), (0x1000, len15), (0x1040, len15), (0x1080, len14); total 50 beats; no burst crosses 0x1000.
3. beats=40, arready held low for 5 cycles on the first burst -> arvalid stays high and araddr=0x0/arlen=15 are stable for all 5 cycles; the next burst follows the handshake after one bubble.
4. MAX_OUTST=2, beats=64, no rlast_hs -> exactly 2 ARs issued, then a stall in CALC. One rlast_hs pulse -> 3rd AR issued. done only after 4 rlast_hs total. rlast_hs coincident with an AR handshake leaves the counter unchanged.
5. beats=0 -> no arvalid; busy high for 1 cycle; done pulses on the 2nd cycle after the handshake.
6. areset asserted while arvalid=1 mid-transfer -> arvalid, busy and outstanding are 0 immediately. After release, a new command (saddr=0x100, beats=4) issues (0x100, len3) normally.

Source files
------------

// File: rtl/axi_raddr_gen.sv
// AXI read-address generator: splits one (address, beat count) command into INCR
// bursts bounded by MAX_BURST and 4 KB pages, with an outstanding-burst limit.
module axi_raddr_gen #(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int MAX_BURST  = 16,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 14,
  parameter int MAX_OUTST  = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_saddr,
  input  logic [CNT_W-1:0]  cmd_beats,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic              rlast_hs,
  output logic              busy,
  output logic              done
);

  localparam int SIZE = $clog2(DATA_BYTES);
  localparam int OW   = $clog2(MAX_OUTST + 1);
  localparam int MW   = (CNT_W > 13) ? CNT_W : 13;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << SIZE;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;
  logic              arvalid_q, arvalid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [OW-1:0]     outst_q, outst_d;

  logic              cmd_hs_s;
  logic              ar_hs_s;
  logic              rl_dec_s;
  logic [MW-1:0]     b4k_s;
  logic [MW-1:0]     rem_cap_s;
  logic [MW-1:0]     blen_s;
  logic [LEN_W:0]    blen_iss_s;
  logic [CNT_W-1:0]  rem_next_s;
  logic [ADDR_W-1:0] step_s;

  assign cmd_ready = cmd_ready_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arvalid   = arvalid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign arsize    = 3'(SIZE);
  assign arburst   = 2'b01;

  // Burst sizing: beats left in the 4 KB page, capped by MAX_BURST and remaining beats
  always_comb begin
    cmd_hs_s   = cmd_valid && cmd_ready_q && (state_q == S_IDLE);
    ar_hs_s    = arvalid_q && arready;
    rl_dec_s   = rlast_hs && (outst_q != {OW{1'b0}});
    b4k_s      = (MW'(13'h1000) - MW'(addr_q[11:0])) >> SIZE;
    rem_cap_s  = (MW'(MAX_BURST) < MW'(rem_q)) ? MW'(MAX_BURST) : MW'(rem_q);
    blen_s     = (b4k_s < rem_cap_s) ? b4k_s : rem_cap_s;
    blen_iss_s = {1'b0, arlen_q} + {{LEN_W{1'b0}}, 1'b1};
    rem_next_s = rem_q - CNT_W'(blen_iss_s);
    step_s     = ADDR_W'(blen_iss_s) << SIZE;
  end

  // Sequencer: next-state and next-output computation
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs_s) begin
          addr_d  = cmd_saddr & ALIGN_MASK;
          rem_d   = cmd_beats;
          busy_d  = 1'b1;
          state_d = (cmd_beats == {CNT_W{1'b0}}) ? S_DRAIN : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        araddr_d = addr_q;
        arlen_d  = LEN_W'(blen_s - MW'(1'b1));
        if (outst_q < OW'(MAX_OUTST)) begin
          arvalid_d = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_ISSUE: begin
        if (ar_hs_s) begin
          arvalid_d = 1'b0;
          addr_d    = addr_q + step_s;
          rem_d     = rem_next_s;
          state_d   = (rem_next_s == {CNT_W{1'b0}}) ? S_DRAIN : S_CALC;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (outst_q == {OW{1'b0}}) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
    // Holding cmd_ready low during the done cycle delays re-acceptance by one cycle
    cmd_ready_d = (state_d == S_IDLE) && !done_d;
  end

  // Outstanding-burst counter; a late rlast with nothing outstanding is dropped
  always_comb begin
    case ({ar_hs_s, rl_dec_s})
      2'b10:   outst_d = outst_q + OW'(1'b1);
      2'b01:   outst_d = outst_q - OW'(1'b1);
      default: outst_d = outst_q;
    endcase
  end

  // State and output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      rem_q       <= {CNT_W{1'b0}};
      araddr_q    <= {ADDR_W{1'b0}};
      arlen_q     <= {LEN_W{1'b0}};
      arvalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      outst_q     <= {OW{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arvalid_q   <= arvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      outst_q     <= outst_d;
    end
  end

endmodule
